// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: states, opcodes,
// instruction classes, imm_gen type codes and datapath mux selects.
package ctrl_pkg;

    localparam int unsigned OPC_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
        CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP
    } cls_e;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    // Codes shared with imm_gen.
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0, IMM_J = 3'd1, IMM_U = 3'd2,
        IMM_S    = 3'd3, IMM_B = 3'd4, IMM_I = 3'd5
    } imm_e;

    typedef enum logic [1:0] {ALU_ADD, ALU_CMP, ALU_FUNCT, ALU_PASS_B} alu_op_e;
    typedef enum logic [1:0] {PC_PLUS4, PC_IMM, PC_JALR} pc_sel_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class, immediate type, legality.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output cls_e             cls_o,
    output imm_e             imm_type_o,
    output logic             legal_o
);

    always_comb begin
        cls_o      = CLS_NONE;
        imm_type_o = IMM_NONE;
        legal_o    = 1'b1;
        case (opcode_i)
            OPC_LUI:    begin cls_o = CLS_LUI;    imm_type_o = IMM_U; end
            OPC_AUIPC:  begin cls_o = CLS_AUIPC;  imm_type_o = IMM_U; end
            OPC_JAL:    begin cls_o = CLS_JAL;    imm_type_o = IMM_J; end
            OPC_JALR:   begin cls_o = CLS_JALR;   imm_type_o = IMM_I; end
            OPC_BRANCH: begin cls_o = CLS_BRANCH; imm_type_o = IMM_B; end
            OPC_LOAD:   begin cls_o = CLS_LOAD;   imm_type_o = IMM_I; end
            OPC_STORE:  begin cls_o = CLS_STORE;  imm_type_o = IMM_S; end
            OPC_OPIMM:  begin cls_o = CLS_OPIMM;  imm_type_o = IMM_I; end
            OPC_OP:     begin cls_o = CLS_OP;     imm_type_o = IMM_NONE; end
            default:    legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb over the
// shared datapath, owns the memory handshake, and halts in a sticky trap.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TIMEOUT_W   = 5
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] instr_w_i,
    input  logic        mem_ready_i,
    input  logic        branch_taken_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_addr_sel_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic        reg_we_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  imm_type_o,
    output logic        alu_src_a_sel_o,
    output logic        alu_src_b_sel_o,
    output logic [1:0]  alu_op_o,
    output logic        retire_o,
    output logic        trap_o
);

    state_e               state_q, state_d;
    cls_e                 cls_q, cls_d, dec_cls;
    imm_e                 imm_q, imm_d, dec_imm;
    logic                 dec_legal;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 timeout_hit;
    logic                 instr_unused;

    ctrl_decode u_decode (
        .opcode_i   (instr_w_i[OPC_W-1:0]),
        .cls_o      (dec_cls),
        .imm_type_o (dec_imm),
        .legal_o    (dec_legal)
    );

    assign instr_unused = ^instr_w_i[31:OPC_W];

    // A zero MEM_TIMEOUT disables the watchdog entirely.
    assign cnt_inc     = cnt_q + TIMEOUT_W'(1);
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc == TIMEOUT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_NONE;
            imm_q   <= IMM_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            imm_q   <= imm_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cls_d           = cls_q;
        imm_d           = imm_q;
        cnt_d           = '0;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_sel_o  = 1'b0;
        ir_we_o         = 1'b0;
        pc_we_o         = 1'b0;
        pc_sel_o        = PC_PLUS4;
        reg_we_o        = 1'b0;
        wb_sel_o        = WB_ALU;
        imm_type_o      = IMM_NONE;
        alu_src_a_sel_o = 1'b0;
        alu_src_b_sel_o = 1'b0;
        alu_op_o        = ALU_ADD;
        retire_o        = 1'b0;
        trap_o          = 1'b0;

        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            imm_type_o = imm_q;
        end

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                mem_req_o = 1'b1;
                ir_we_o   = mem_ready_i;
                if (mem_ready_i)      state_d = ST_DECODE;
                else if (timeout_hit) state_d = ST_TRAP;
                else                  cnt_d   = cnt_inc;
            end

            ST_DECODE: begin
                cls_d   = dec_cls;
                imm_d   = dec_imm;
                state_d = dec_legal ? ST_EXEC : ST_TRAP;
            end

            ST_EXEC: begin
                state_d = ST_WB;
                case (cls_q)
                    CLS_OP:    alu_op_o = ALU_FUNCT;
                    CLS_OPIMM: begin alu_op_o = ALU_FUNCT; alu_src_b_sel_o = 1'b1; end
                    CLS_LUI:   begin alu_op_o = ALU_PASS_B; alu_src_b_sel_o = 1'b1; end
                    CLS_AUIPC: begin alu_src_a_sel_o = 1'b1; alu_src_b_sel_o = 1'b1; end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b_sel_o = 1'b1;
                        state_d         = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op_o = ALU_CMP;
                        pc_we_o  = 1'b1;
                        pc_sel_o = branch_taken_i ? PC_IMM : PC_PLUS4;
                        retire_o = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_JAL:   alu_op_o = ALU_ADD;
                    CLS_JALR:  alu_src_b_sel_o = 1'b1;
                    default:   state_d = ST_TRAP;
                endcase
            end

            ST_MEM: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                mem_we_o       = (cls_q == CLS_STORE);
                if (mem_ready_i) begin
                    if (cls_q == CLS_STORE) begin
                        pc_we_o  = 1'b1;
                        retire_o = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_WB: begin
                reg_we_o = 1'b1;
                pc_we_o  = 1'b1;
                retire_o = 1'b1;
                state_d  = ST_FETCH;
                case (cls_q)
                    CLS_LOAD: wb_sel_o = WB_MEM;
                    CLS_JAL:  begin wb_sel_o = WB_PC4; pc_sel_o = PC_IMM; end
                    CLS_JALR: begin wb_sel_o = WB_PC4; pc_sel_o = PC_JALR; end
                    default:  wb_sel_o = WB_ALU;
                endcase
            end

            ST_TRAP: trap_o = 1'b1;

            default: state_d = ST_TRAP;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table, hand-written corner sequences and a
// randomized instruction stream checked against a per-instruction trace model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       req, we, asel, irwe, pcwe;
        logic [1:0] pcsel;
        logic       regwe;
        logic [1:0] wbsel;
        logic [2:0] imm;
        logic       a, b;
        logic [1:0] op;
        logic       ret, trap;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        logic        tk;
        int          lat;
        out_t        exec_o;
        out_t        last_o;
    } vec_t;

    localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JAL = 7'b1101111;
    localparam logic [6:0] O_JALR = 7'b1100111, O_BR = 7'b1100011, O_LD = 7'b0000011;
    localparam logic [6:0] O_ST = 7'b0100011, O_OPI = 7'b0010011, O_OP = 7'b0110011;
    localparam out_t ZERO = '0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        ready = 1'b0;
    logic        taken = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic       req0, we0, asel0, irwe0, pcwe0, regwe0, a0, b0, ret0, trap0;
    logic [1:0] pcsel0, wbsel0, op0;
    logic [2:0] imm0;
    logic       req4, we4, asel4, irwe4, pcwe4, regwe4, a4, b4, ret4, trap4;
    logic [1:0] pcsel4, wbsel4, op4;
    logic [2:0] imm4;
    out_t       act0, act4;

    always #5 clk = ~clk;

    multicycle_ctrl u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .instr_w_i(instr), .mem_ready_i(ready),
        .branch_taken_i(taken), .mem_req_o(req0), .mem_we_o(we0), .mem_addr_sel_o(asel0),
        .ir_we_o(irwe0), .pc_we_o(pcwe0), .pc_sel_o(pcsel0), .reg_we_o(regwe0),
        .wb_sel_o(wbsel0), .imm_type_o(imm0), .alu_src_a_sel_o(a0), .alu_src_b_sel_o(b0),
        .alu_op_o(op0), .retire_o(ret0), .trap_o(trap0)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(4), .TIMEOUT_W(5)) u_dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .instr_w_i(instr), .mem_ready_i(ready),
        .branch_taken_i(taken), .mem_req_o(req4), .mem_we_o(we4), .mem_addr_sel_o(asel4),
        .ir_we_o(irwe4), .pc_we_o(pcwe4), .pc_sel_o(pcsel4), .reg_we_o(regwe4),
        .wb_sel_o(wbsel4), .imm_type_o(imm4), .alu_src_a_sel_o(a4), .alu_src_b_sel_o(b4),
        .alu_op_o(op4), .retire_o(ret4), .trap_o(trap4)
    );

    assign act0 = {req0, we0, asel0, irwe0, pcwe0, pcsel0, regwe0, wbsel0, imm0, a0, b0, op0, ret0, trap0};
    assign act4 = {req4, we4, asel4, irwe4, pcwe4, pcsel4, regwe4, wbsel4, imm4, a4, b4, op4, ret4, trap4};

    task automatic check(input out_t exp, input string nm, input bit sel4);
        out_t act;
        act = sel4 ? act4 : act0;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%05h exp=%05h", nm, $time, act, exp);
        end
    endtask

    // Called at posedge+1; drives inputs, samples at negedge, returns at next posedge+1.
    task automatic step(input logic rdy, input logic tk, input out_t exp, input string nm, input bit sel4);
        ready = rdy;
        taken = tk;
        @(negedge clk);
        check(exp, nm, sel4);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ready = 1'b0;
        taken = 1'b0;
        @(negedge clk);
        check(ZERO, "rst_out", 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, ZERO, "rst_idle", 1'b0);
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] opc);
        case (opc)
            O_LUI, O_AUIPC:      return 3'd2;
            O_JAL:               return 3'd1;
            O_JALR, O_LD, O_OPI: return 3'd5;
            O_ST:                return 3'd3;
            O_BR:                return 3'd4;
            default:             return 3'd0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] opc);
        return opc inside {O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_OPI, O_OP};
    endfunction

    // Reference trace of one instruction from FETCH to retire (or trap).
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic tk, output bit trapped);
        logic [6:0] opc;
        out_t       e;
        opc     = ins[6:0];
        instr   = ins;
        trapped = 1'b0;
        e = '{req:1'b1, default:'0};
        for (int i = 0; i < fw; i++) step(1'b0, tk, e, "rnd_fetch_wait", 1'b0);
        e.irwe = 1'b1;
        step(1'b1, tk, e, "rnd_fetch", 1'b0);
        step(1'($urandom()), tk, ZERO, "rnd_decode", 1'b0);
        if (!is_legal(opc)) begin
            for (int i = 0; i < 3; i++) step(1'($urandom()), tk, '{trap:1'b1, default:'0}, "rnd_trap", 1'b0);
            trapped = 1'b1;
            return;
        end
        e = '0;
        e.imm = imm_of(opc);
        case (opc)
            O_OP:         e.op = 2'd2;
            O_OPI:        begin e.op = 2'd2; e.b = 1'b1; end
            O_LUI:        begin e.op = 2'd3; e.b = 1'b1; end
            O_AUIPC:      begin e.a = 1'b1; e.b = 1'b1; end
            O_LD, O_ST:   e.b = 1'b1;
            O_JALR:       e.b = 1'b1;
            O_BR:         begin e.op = 2'd1; e.pcwe = 1'b1; e.pcsel = tk ? 2'd1 : 2'd0; e.ret = 1'b1; end
            default:      e.op = 2'd0;
        endcase
        step(1'($urandom()), tk, e, "rnd_exec", 1'b0);
        if (opc == O_BR) return;
        if (opc == O_LD || opc == O_ST) begin
            e = '{req:1'b1, asel:1'b1, default:'0};
            e.we  = (opc == O_ST);
            e.imm = imm_of(opc);
            for (int i = 0; i < mw; i++) step(1'b0, tk, e, "rnd_mem_wait", 1'b0);
            if (opc == O_ST) begin
                e.pcwe = 1'b1;
                e.ret  = 1'b1;
            end
            step(1'b1, tk, e, "rnd_mem", 1'b0);
            if (opc == O_ST) return;
        end
        e = '{regwe:1'b1, pcwe:1'b1, ret:1'b1, default:'0};
        e.imm   = imm_of(opc);
        e.wbsel = (opc == O_LD) ? 2'd1 : (opc == O_JAL || opc == O_JALR) ? 2'd2 : 2'd0;
        e.pcsel = (opc == O_JAL) ? 2'd1 : (opc == O_JALR) ? 2'd2 : 2'd0;
        step(1'($urandom()), tk, e, "rnd_wb", 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t        vt[10];
        logic [6:0]  legal_ops[9];
        logic [31:0] r;
        logic [6:0]  opc;
        bit          tr, done;
        out_t        e;

        legal_ops = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_OPI, O_OP};
        vt[0] = '{32'h00500093, 1'b0, 4, '{imm:3'd5, b:1'b1, op:2'd2, default:'0},
                  '{imm:3'd5, regwe:1'b1, pcwe:1'b1, ret:1'b1, default:'0}};
        vt[1] = '{32'h00000463, 1'b1, 3, '{imm:3'd4, op:2'd1, pcwe:1'b1, pcsel:2'd1, ret:1'b1, default:'0},
                  '{imm:3'd4, op:2'd1, pcwe:1'b1, pcsel:2'd1, ret:1'b1, default:'0}};
        vt[2] = '{32'h00000463, 1'b0, 3, '{imm:3'd4, op:2'd1, pcwe:1'b1, ret:1'b1, default:'0},
                  '{imm:3'd4, op:2'd1, pcwe:1'b1, ret:1'b1, default:'0}};
        vt[3] = '{32'h123450b7, 1'b0, 4, '{imm:3'd2, op:2'd3, b:1'b1, default:'0},
                  '{imm:3'd2, regwe:1'b1, pcwe:1'b1, ret:1'b1, default:'0}};
        vt[4] = '{32'h00001097, 1'b1, 4, '{imm:3'd2, a:1'b1, b:1'b1, default:'0},
                  '{imm:3'd2, regwe:1'b1, pcwe:1'b1, ret:1'b1, default:'0}};
        vt[5] = '{32'h008000ef, 1'b0, 4, '{imm:3'd1, default:'0},
                  '{imm:3'd1, regwe:1'b1, wbsel:2'd2, pcwe:1'b1, pcsel:2'd1, ret:1'b1, default:'0}};
        vt[6] = '{32'h000080e7, 1'b0, 4, '{imm:3'd5, b:1'b1, default:'0},
                  '{imm:3'd5, regwe:1'b1, wbsel:2'd2, pcwe:1'b1, pcsel:2'd2, ret:1'b1, default:'0}};
        vt[7] = '{32'h0000a083, 1'b0, 5, '{imm:3'd5, b:1'b1, default:'0},
                  '{imm:3'd5, regwe:1'b1, wbsel:2'd1, pcwe:1'b1, ret:1'b1, default:'0}};
        vt[8] = '{32'h0010a023, 1'b0, 4, '{imm:3'd3, b:1'b1, default:'0},
                  '{imm:3'd3, req:1'b1, asel:1'b1, we:1'b1, pcwe:1'b1, ret:1'b1, default:'0}};
        vt[9] = '{32'h002081b3, 1'b1, 4, '{op:2'd2, default:'0},
                  '{regwe:1'b1, pcwe:1'b1, ret:1'b1, default:'0}};

        do_reset();

        // Zero-wait vector table: EXEC-cycle outputs, latency and retire-cycle outputs.
        foreach (vt[k]) begin
            instr = vt[k].instr;
            taken = vt[k].tk;
            ready = 1'b1;
            done  = 1'b0;
            for (int c = 1; c <= 10 && !done; c++) begin
                @(negedge clk);
                if (c == 3) check(vt[k].exec_o, $sformatf("vec%0d_exec", k), 1'b0);
                if (act0.ret) begin
                    checks++;
                    if (c != vt[k].lat) begin
                        errors++;
                        $display("FAIL vec%0d_latency act=%0d exp=%0d", k, c, vt[k].lat);
                    end
                    check(vt[k].last_o, $sformatf("vec%0d_last", k), 1'b0);
                    done = 1'b1;
                end
                @(posedge clk);
                #1;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL vec%0d_no_retire act=none exp=retire", k);
            end
        end

        // Reset in the middle of a LOAD's MEM wait.
        instr = 32'h0000a083;
        step(1'b1, 1'b0, '{req:1'b1, irwe:1'b1, default:'0}, "t1_fetch", 1'b0);
        step(1'b1, 1'b0, ZERO, "t1_decode", 1'b0);
        step(1'b0, 1'b0, '{imm:3'd5, b:1'b1, default:'0}, "t1_exec", 1'b0);
        @(negedge clk);
        check('{req:1'b1, asel:1'b1, imm:3'd5, default:'0}, "t1_mem", 1'b0);
        rst_n = 1'b0;
        #1 check(ZERO, "t1_async_rst", 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, ZERO, "t1_idle", 1'b0);
        step(1'b0, 1'b0, '{req:1'b1, default:'0}, "t1_fetch_after", 1'b0);
        do_reset();

        // Memory wait states in MEM for a load and a store.
        run_instr(32'h0000a083, 0, 3, 1'b0, tr);
        run_instr(32'h0010a023, 1, 2, 1'b0, tr);

        // Illegal opcode: sticky trap until reset.
        instr = 32'h0000007f;
        step(1'b1, 1'b0, '{req:1'b1, irwe:1'b1, default:'0}, "t5_fetch", 1'b0);
        step(1'b1, 1'b0, ZERO, "t5_decode", 1'b0);
        for (int i = 0; i < 20; i++) step(1'($urandom()), 1'($urandom()), '{trap:1'b1, default:'0}, "t5_trap", 1'b0);
        do_reset();

        // Short watchdog: fetch timeout, then ready arriving on the last allowed cycle.
        instr = 32'h00500093;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '{req:1'b1, default:'0}, "t6_wait", 1'b1);
        step(1'b0, 1'b0, '{trap:1'b1, default:'0}, "t6_trap", 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '{req:1'b1, default:'0}, "t6b_wait", 1'b1);
        step(1'b1, 1'b0, '{req:1'b1, irwe:1'b1, default:'0}, "t6b_ready_wins", 1'b1);
        step(1'b0, 1'b0, ZERO, "t6b_decode", 1'b1);
        do_reset();

        // Default watchdog expiring in MEM.
        instr = 32'h0000a083;
        step(1'b1, 1'b0, '{req:1'b1, irwe:1'b1, default:'0}, "tmo_fetch", 1'b0);
        step(1'b1, 1'b0, ZERO, "tmo_decode", 1'b0);
        step(1'b0, 1'b0, '{imm:3'd5, b:1'b1, default:'0}, "tmo_exec", 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '{req:1'b1, asel:1'b1, imm:3'd5, default:'0}, "tmo_mem", 1'b0);
        step(1'b1, 1'b0, '{trap:1'b1, default:'0}, "tmo_trap", 1'b0);
        do_reset();

        // Randomized instruction stream with random wait states.
        for (int n = 0; n < 150; n++) begin
            r = $urandom();
            if ($urandom_range(0, 9) == 0) begin
                do opc = 7'($urandom_range(0, 127)); while (is_legal(opc));
            end else begin
                opc = legal_ops[$urandom_range(0, 8)];
            end
            run_instr({r[31:7], opc}, $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom()), tr);
            if (tr) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
